// File: rtl/pong_ctrl_pkg.sv
// Shared types for the Pong match sequencer: FSM state and winner encodings,
// frame counter width and the win-decision helper.
package pong_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10,
        WIN_TIE   = 2'b11
    } winner_e;

    localparam int FRAME_CNT_W = 16;

    // Both sides at or above the threshold in the same cycle is reported as a tie.
    function automatic winner_e judge(input logic [7:0] sl, input logic [7:0] sr,
                                      input logic [7:0] thr);
        logic l_win;
        logic r_win;
        l_win = (sl >= thr);
        r_win = (sr >= thr);
        if (l_win && r_win) return WIN_TIE;
        if (l_win)          return WIN_LEFT;
        if (r_win)          return WIN_RIGHT;
        return WIN_NONE;
    endfunction

endpackage

// File: rtl/frame_btn_edge.sv
// Frame-rate button debouncer: samples a raw button on each frame strobe and
// emits a 1-cycle event in the cycle after a strobe that saw a 0->1 change.
module frame_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_stb,
    input  logic i_btn,
    output logic o_evt
);

    logic r_sample;
    logic r_prev;
    logic r_stb_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= 1'b0;
            r_prev   <= 1'b0;
            r_stb_d  <= 1'b0;
        end else begin
            r_stb_d <= i_stb;
            if (i_stb) begin
                r_sample <= i_btn;
                r_prev   <= r_sample;
            end
        end
    end

    // Qualified by the delayed strobe so a held button yields a single event.
    assign o_evt = r_stb_d & r_sample & ~r_prev;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer for the VGA Pong generator (idle/clear/play/pause/over).
// Define PONG_MATCH_PAUSE_EN to build the pause button and the PAUSE state.
module pong_match_ctrl
    import pong_ctrl_pkg::*;
#(
    parameter logic [7:0] WIN_SCORE    = 8'd11,
    parameter int         RST_FRAMES   = 2,
    parameter int         BLINK_FRAMES = 16,
    parameter int         OVER_FRAMES  = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_stb,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [3:0] btn_in,
    input  logic [7:0] score_L,
    input  logic [7:0] score_R,
    output logic       game_rst,
    output logic       game_en,
    output logic [3:0] player_buttons,
    output logic       draw_score,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam int BLINK_W = $clog2(2 * BLINK_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] RST_LAST   = FRAME_CNT_W'(RST_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] OVER_LAST  = FRAME_CNT_W'(OVER_FRAMES - 1);
    localparam logic [BLINK_W-1:0]     BLINK_HALF = BLINK_W'(BLINK_FRAMES);
    localparam logic [BLINK_W-1:0]     BLINK_LAST = BLINK_W'(2 * BLINK_FRAMES - 1);

    state_e                 r_state, w_state_next;
    winner_e                r_winner, w_winner_next, w_win;
    logic [FRAME_CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic [BLINK_W-1:0]     r_blink, w_blink_next, w_blink_step;
    logic                   w_start_evt;
    logic                   w_pause_evt;

    frame_btn_edge u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .i_stb (frame_stb),
        .i_btn (start_btn),
        .o_evt (w_start_evt)
    );

`ifdef PONG_MATCH_PAUSE_EN
    frame_btn_edge u_pause_edge (
        .clk   (clk),
        .rst   (rst),
        .i_stb (frame_stb),
        .i_btn (pause_btn),
        .o_evt (w_pause_evt)
    );
`else
    logic w_unused_pause;
    assign w_unused_pause = pause_btn;
    assign w_pause_evt    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_winner <= WIN_NONE;
            r_cnt    <= '0;
            r_blink  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_winner <= w_winner_next;
            r_cnt    <= w_cnt_next;
            r_blink  <= w_blink_next;
        end
    end

    assign w_win        = judge(score_L, score_R, WIN_SCORE);
    assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_blink_step = !frame_stb ? r_blink :
                          (r_blink == BLINK_LAST) ? '0 : r_blink + 1'b1;

    always_comb begin
        w_state_next  = r_state;
        w_winner_next = r_winner;
        w_cnt_next    = r_cnt;
        w_blink_next  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_evt) begin
                    w_state_next  = ST_CLEAR;
                    w_winner_next = WIN_NONE;
                    w_cnt_next    = '0;
                end
            end
            ST_CLEAR: begin
                if (frame_stb) begin
                    if (r_cnt == RST_LAST) begin
                        w_state_next = ST_PLAY;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end
            ST_PLAY: begin
                if (w_win != WIN_NONE) begin
                    w_state_next  = ST_OVER;
                    w_winner_next = w_win;
                    w_cnt_next    = '0;
                end else if (w_pause_evt) begin
                    w_state_next = ST_PAUSE;
                    w_cnt_next   = '0;
                end
            end
            ST_PAUSE: begin
                w_blink_next = w_blink_step;
                if (w_start_evt) begin
                    w_state_next  = ST_CLEAR;
                    w_winner_next = WIN_NONE;
                    w_cnt_next    = '0;
                end else if (w_pause_evt) begin
                    w_state_next = ST_PLAY;
                end
            end
            ST_OVER: begin
                w_blink_next = w_blink_step;
                if (w_start_evt) begin
                    w_state_next  = ST_CLEAR;
                    w_winner_next = WIN_NONE;
                    w_cnt_next    = '0;
                end else if (frame_stb) begin
                    if (r_cnt == OVER_LAST) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are forced to their reset values while rst is high, whatever the state.
    assign game_rst       = rst | (r_state == ST_CLEAR);
    assign game_en        = ~rst & (r_state == ST_PLAY) & frame_stb;
    assign player_buttons = (~rst && r_state == ST_PLAY) ? btn_in : 4'b0000;
    assign draw_score     = rst | ~((r_state == ST_PAUSE) || (r_state == ST_OVER))
                            | (r_blink < BLINK_HALF);
    assign winner         = r_winner;
    assign state          = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl with default parameters
// (WIN_SCORE=11, RST_FRAMES=2, BLINK_FRAMES=16, OVER_FRAMES=600).
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       rst, frame_stb, start_btn, pause_btn;
    logic [3:0] btn_in;
    logic [7:0] score_L, score_R;
    logic       game_rst, game_en, draw_score;
    logic [3:0] player_buttons;
    logic [1:0] winner;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int S_IDLE = 0, S_CLEAR = 1, S_PLAY = 2, S_PAUSE = 3, S_OVER = 4;

    typedef struct {
        logic [7:0] sl;
        logic [7:0] sr;
        logic [3:0] btn;
        logic [1:0] exp_win;
        logic [2:0] exp_state;
    } vec_t;

    vec_t vecs[9];

    pong_match_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .frame_stb      (frame_stb),
        .start_btn      (start_btn),
        .pause_btn      (pause_btn),
        .btn_in         (btn_in),
        .score_L        (score_L),
        .score_R        (score_R),
        .game_rst       (game_rst),
        .game_en        (game_en),
        .player_buttons (player_buttons),
        .draw_score     (draw_score),
        .winner         (winner),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: a strobe cycle followed by three quiet cycles.
    task automatic frame();
        frame_stb = 1'b1;
        tick();
        frame_stb = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic frame_en(input int exp_en);
        frame_stb = 1'b1;
        #1;
        chk("game_en_stb", int'(game_en), exp_en);
        tick();
        frame_stb = 1'b0;
        #1;
        chk("game_en_quiet", int'(game_en), 0);
        tick();
        tick();
        tick();
    endtask

    task automatic start_game();
        start_btn = 1'b1;
        frame();
        chk("start_to_clear", int'(state), S_CLEAR);
        chk("clear_winner", int'(winner), 0);
        chk("clear_game_rst", int'(game_rst), 1);
        start_btn = 1'b0;
        frame();
        chk("clear_hold", int'(state), S_CLEAR);
        frame();
        chk("clear_to_play", int'(state), S_PLAY);
        chk("play_game_rst", int'(game_rst), 0);
    endtask

    initial begin
        vecs[0] = '{8'd0,   8'd0,   4'hA, 2'b00, 3'd2};
        vecs[1] = '{8'd10,  8'd10,  4'h5, 2'b00, 3'd2};
        vecs[2] = '{8'd10,  8'd0,   4'hF, 2'b00, 3'd2};
        vecs[3] = '{8'd11,  8'd10,  4'h3, 2'b01, 3'd4};
        vecs[4] = '{8'd10,  8'd12,  4'hC, 2'b10, 3'd4};
        vecs[5] = '{8'd11,  8'd11,  4'h1, 2'b11, 3'd4};
        vecs[6] = '{8'd255, 8'd0,   4'h2, 2'b01, 3'd4};
        vecs[7] = '{8'd0,   8'd200, 4'h6, 2'b10, 3'd4};
        vecs[8] = '{8'd11,  8'd254, 4'h9, 2'b11, 3'd4};

        rst = 1'b1; frame_stb = 1'b1; start_btn = 1'b0; pause_btn = 1'b0;
        btn_in = 4'hF; score_L = 8'd0; score_R = 8'd0;
        tick();
        tick();
        chk("rst_state", int'(state), S_IDLE);
        chk("rst_winner", int'(winner), 0);
        chk("rst_game_rst", int'(game_rst), 1);
        chk("rst_game_en", int'(game_en), 0);
        chk("rst_buttons", int'(player_buttons), 0);
        chk("rst_draw", int'(draw_score), 1);
        rst = 1'b0; frame_stb = 1'b0; btn_in = 4'h0;
        tick();
        chk("idle_game_rst", int'(game_rst), 0);
        chk("idle_state", int'(state), S_IDLE);

        start_game();
        frame_en(1);

        for (int i = 0; i < 9; i++) begin
            score_L = vecs[i].sl;
            score_R = vecs[i].sr;
            btn_in  = vecs[i].btn;
            #1;
            chk("vec_buttons", int'(player_buttons), int'(vecs[i].btn));
            tick();
            chk("vec_state", int'(state), int'(vecs[i].exp_state));
            chk("vec_winner", int'(winner), int'(vecs[i].exp_win));
            $display("vec %0d: L=%0d R=%0d -> state=%0d winner=%0d", i,
                     vecs[i].sl, vecs[i].sr, state, winner);
            if (vecs[i].exp_state == 3'd4) begin
                chk("over_buttons", int'(player_buttons), 0);
                score_L = 8'd0;
                score_R = 8'd0;
                start_game();
            end
        end

        // Left win, blink in OVER, then timeout back to IDLE.
        score_L = 8'd10;
        tick();
        chk("l10_play", int'(state), S_PLAY);
        score_L = 8'd11;
        tick();
        chk("l11_over", int'(state), S_OVER);
        chk("l11_winner", int'(winner), 1);
        score_L = 8'd0;
        frame_en(0);
        chk("over_draw_1", int'(draw_score), 1);
        for (int n = 2; n <= 599; n++) begin
            frame();
            chk("over_draw", int'(draw_score), ((n % 32) < 16) ? 1 : 0);
        end
        chk("over_599", int'(state), S_OVER);
        frame();
        chk("over_timeout", int'(state), S_IDLE);
        chk("idle_keeps_winner", int'(winner), 1);
        chk("idle_draw", int'(draw_score), 1);
        $display("timeout: state=%0d winner=%0d", state, winner);

        // Held start gives one CLEAR entry only.
        start_btn = 1'b1;
        for (int f = 1; f <= 50; f++) begin
            frame();
            chk("held_start", int'(state), (f <= 2) ? S_CLEAR : S_PLAY);
        end
        start_btn = 1'b0;
        frame();
        chk("held_release", int'(state), S_PLAY);
        score_R = 8'd11;
        tick();
        chk("r_win_state", int'(state), S_OVER);
        chk("r_win_winner", int'(winner), 2);
        score_R = 8'd0;
        start_game();

`ifdef PONG_MATCH_PAUSE_EN
        btn_in = 4'hF;
        pause_btn = 1'b1;
        frame();
        chk("pause_enter", int'(state), S_PAUSE);
        chk("pause_buttons", int'(player_buttons), 0);
        pause_btn = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            frame_en(0);
            chk("pause_draw", int'(draw_score), ((n % 32) < 16) ? 1 : 0);
        end
        pause_btn = 1'b1;
        frame();
        chk("pause_resume", int'(state), S_PLAY);
        pause_btn = 1'b0;
        frame_en(1);
        chk("resume_buttons", int'(player_buttons), 15);

        // Tie arriving with a pause event: win takes priority.
        pause_btn = 1'b1;
        frame_stb = 1'b1;
        tick();
        frame_stb = 1'b0;
        score_L = 8'd11;
        score_R = 8'd11;
        tick();
        chk("tie_state", int'(state), S_OVER);
        chk("tie_winner", int'(winner), 3);
        tick();
        tick();
        chk("tie_hold", int'(state), S_OVER);
        pause_btn = 1'b0;
        score_L = 8'd0;
        score_R = 8'd0;
        start_game();

        // Start and pause together in PAUSE restart the match.
        pause_btn = 1'b1;
        frame();
        chk("pause2_enter", int'(state), S_PAUSE);
        pause_btn = 1'b0;
        frame();
        pause_btn = 1'b1;
        start_btn = 1'b1;
        frame();
        chk("pause_start_prio", int'(state), S_CLEAR);
        pause_btn = 1'b0;
        start_btn = 1'b0;
        frame();
        frame();
        chk("restart_play", int'(state), S_PLAY);
`else
        for (int k = 0; k < 6; k++) begin
            pause_btn = (k % 2 == 0);
            frame_en(1);
            chk("nopause_play", int'(state), S_PLAY);
        end
        pause_btn = 1'b0;
`endif

        // Reset mid-game clears everything the next cycle.
        btn_in = 4'hF;
        score_L = 8'd11;
        tick();
        chk("pre_rst_winner", int'(winner), 1);
        rst = 1'b1;
        score_L = 8'd0;
        tick();
        chk("midrst_state", int'(state), S_IDLE);
        chk("midrst_winner", int'(winner), 0);
        chk("midrst_game_rst", int'(game_rst), 1);
        chk("midrst_buttons", int'(player_buttons), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_state", int'(state), S_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match sequencer for the VGA Pong generator.
- Runs start / clear / play / pause / game-over.
- Drives the generator's reset and enable, gates paddle buttons, and blinks the score overlay.
- Detects the winning score.
- All timing is counted in frames, using the 1-cycle VSYNC strobe.

Parameters:
- WIN_SCORE, 8'd11: first side whose score_* >= this value wins.
- RST_FRAMES, 2: number of frame strobes that game_rst is held in CLEAR (must be >= 1).
- BLINK_FRAMES, 16: frames per half-period of the score blink in PAUSE/OVER.
- OVER_FRAMES, 600: frames spent in OVER before auto-return to IDLE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_stb  in  1  1-cycle VSYNC strobe, once per frame
- start_btn  in  1  raw start button
- pause_btn  in  1  raw pause button
- btn_in  in  4  raw paddle buttons {R_down, R_up, L_down, L_up}
- score_L  in  8  left score from generator
- score_R  in  8  right score from generator
- game_rst  out  1  reset to generator
- game_en  out  1  enable to generator
- player_buttons  out  4  gated paddle buttons
- draw_score  out  1  score overlay enable
- winner  out  2  00 none, 01 left, 10 right, 11 tie
- state  out  3  current FSM state, for debug/LEDs

Behaviour:
- Clocking: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state = IDLE, winner = 00, frame counter = 0, button samples = 0.
- Reset outputs: game_rst = 1 (combinational: rst | state==CLEAR), game_en = 0, player_buttons = 0, draw_score = 1.
- Button sampling:
  - start_btn and pause_btn are registered only on frame_stb.
  - An edge event is sample==1 & previous sample==0, evaluated in the frame_stb cycle. This gives a frame-rate debounce.
  - An event is seen by the FSM in the cycle after the sampling frame_stb.
  - Holding a button produces one event only.
- States and encodings: IDLE=0, CLEAR=1, PLAY=2, PAUSE=3, OVER=4.
- IDLE:
  - game_en = 0; generator frozen with last scene shown.
  - start event -> CLEAR; counter = 0.
- CLEAR:
  - game_rst = 1; winner cleared to 00 on entry.
  - Counter increments on each frame_stb.
  - When counter reaches RST_FRAMES-1 and frame_stb is high -> PLAY; counter = 0.
  - start/pause events are ignored.
- PLAY:
  - game_en = frame_stb (combinational, same cycle).
  - player_buttons = btn_in.
  - Win check runs every cycle and has priority over pause:
    - score_L >= WIN_SCORE and score_R >= WIN_SCORE -> winner = 11.
    - Otherwise score_L >= WIN_SCORE -> winner = 01.
    - Otherwise score_R >= WIN_SCORE -> winner = 10.
    - Any win -> OVER; counter = 0.
  - Otherwise a pause event -> PAUSE; counter = 0.
  - A start event is ignored.
- PAUSE:
  - game_en = 0; player_buttons = 0.
  - pause event -> PLAY.
  - start event -> CLEAR (restart); start has priority if both occur together.
- OVER:
  - game_en = 0; winner held.
  - start event -> CLEAR.
  - Otherwise, counter reaching OVER_FRAMES-1 on frame_stb -> IDLE; winner is retained in IDLE.
- player_buttons is 0 in every state except PLAY.
- draw_score:
  - 1 in IDLE, CLEAR and PLAY.
  - In PAUSE/OVER a blink counter starts at 0 on entry; draw_score = 1 for BLINK_FRAMES frames, then 0 for BLINK_FRAMES frames, repeating.
- Counter widths:
  - Frame counter is 16 bits, saturating; no wrap.
  - Blink counter is $clog2(2*BLINK_FRAMES) bits and wraps.
- Score compare is unsigned 8-bit.
- rst asserted mid-game returns to IDLE next cycle; no state is retained.

Optional Feature:
- Macro: PONG_MATCH_PAUSE_EN.
- Defined: pause_btn handling and the PAUSE state behave as above.
- Undefined:
  - pause_btn is unused; no sampling register is built.
  - PAUSE is unreachable; PLAY exits only on a win or rst.
  - The state encoding is unchanged.

Decomposition:
- Package pong_ctrl_pkg:
  - state enum (3-bit: IDLE, CLEAR, PLAY, PAUSE, OVER)
  - winner encodings (NONE, LEFT, RIGHT, TIE)
  - frame counter width constant
- Sub-module frame_btn_edge:
  - one instance per button (start, pause)
  - frame_stb-qualified sample register, previous-sample register, 1-cycle event output.

Test Plan:
- Reset then start: assert rst 2 cycles, then start_btn high across one frame_stb -> state=CLEAR and game_rst=1 for exactly 2 frame_stb (RST_FRAMES=2), then state=PLAY with game_en pulsing with frame_stb.
- Left win: in PLAY, drive score_L=8'd10 then 8'd11 -> state=OVER next cycle, winner=01, game_en=0; after 600 frame_stb -> state=IDLE with winner still 01.
- Tie and priority: in PLAY, set score_L=score_R=8'd11 together with a pause event -> OVER with winner=11; pause is ignored.
- Pause and blink: pause event in PLAY -> PAUSE; player_buttons=0 with btn_in=4'hF; draw_score is 1 for 16 frames, 0 for 16, 1 again; a second pause event -> PLAY and game_en resumes.
- Held button: hold start_btn high for 50 frames from IDLE -> exactly one CLEAR entry; releasing and pressing in OVER -> CLEAR with winner cleared to 00.
- Build without PONG_MATCH_PAUSE_EN: pause_btn toggled during PLAY -> state stays PLAY, game_en unaffected.
